// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Request tracking state of the fetch stage.
  //   IDLE: no memory request outstanding
  //   WAIT: one request outstanding, its response will be delivered to decode
  //   DROP: one request outstanding, its response belongs to a squashed path
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Every instruction occupies one aligned word.
  localparam int INSTR_BYTES = 4;

  // Reset vector used when the instantiating datapath does not override it.
  localparam logic [31:0] DEFAULT_BOOT_ADDRESS = 32'h0000_1000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instruction, pc} holding register for pipeline back-pressure.
// Latency: a loaded entry is visible the cycle after load.
// Backpressure: none of its own; owner decides when to load, drain or clear.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   load / load_instruction /
//   load_pc                    capture a new entry (wins over drain)
//   drain                      entry was consumed by the owner this cycle
//   clear                      squash the entry (wins over everything)
//   valid / instruction / pc   current contents
module fetch_skid_buffer #(
  parameter int ADDRESS_SIZE = 32,
  parameter int INSTR_SIZE   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [INSTR_SIZE-1:0]   load_instruction,
  input  logic [ADDRESS_SIZE-1:0] load_pc,
  input  logic                    drain,
  input  logic                    clear,
  output logic                    valid,
  output logic [INSTR_SIZE-1:0]   instruction,
  output logic [ADDRESS_SIZE-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= 1'b0;
      instruction <= '0;
      pc          <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as a drain refills the slot.
      valid       <= 1'b1;
      instruction <= load_instruction;
      pc          <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the pc, issues word reads, presents {instr, pc} to decode.
// Latency: request issued the cycle the stage is free; response registered to decode next edge.
// Backpressure: decode stall holds the output slot; spills to skid; no request while skid full.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   imem_req_valid/addr/ready           word read request channel (addr = pc)
//   imem_resp_valid/data                read response, one per request, never stalled
//   redirect_valid/target               control-flow redirect; squashes in-flight work
//   fetch_valid/instruction/pc          pipeline register towards decode
//   decode_ready                        decode consumes the presented instruction
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                      ADDRESS_SIZE = 32,
  parameter int                      INSTR_SIZE   = 32,
  parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = ADDRESS_SIZE'(DEFAULT_BOOT_ADDRESS)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req_valid,
  output logic [ADDRESS_SIZE-1:0] imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_resp_valid,
  input  logic [INSTR_SIZE-1:0]   imem_resp_data,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_SIZE-1:0] redirect_target,
  output logic                    fetch_valid,
  output logic [INSTR_SIZE-1:0]   fetch_instruction,
  output logic [ADDRESS_SIZE-1:0] fetch_pc,
  input  logic                    decode_ready
);

  localparam logic [ADDRESS_SIZE-1:0] PC_STEP    = ADDRESS_SIZE'(INSTR_BYTES);
  localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~ADDRESS_SIZE'(INSTR_BYTES - 1);

  fetch_state_t            state;
  fetch_state_t            state_nxt;
  logic [ADDRESS_SIZE-1:0] pc;
  logic [ADDRESS_SIZE-1:0] req_pc;

  logic                    skid_valid;
  logic [INSTR_SIZE-1:0]   skid_instruction;
  logic [ADDRESS_SIZE-1:0] skid_pc;

  logic req_fire;
  logic decode_fire;
  logic resp_keep;
  logic out_free;
  logic out_from_skid;
  logic out_from_resp;
  logic skid_load;

  // A new fetch is only started when its result is guaranteed a home: the
  // output slot is empty or being consumed, and the skid is empty.
  assign imem_req_valid = ~reset && (state == IDLE) && ~skid_valid && ~redirect_valid &&
                          (~fetch_valid || decode_ready);
  assign imem_req_addr  = pc;

  assign req_fire      = imem_req_valid & imem_req_ready;
  assign decode_fire   = fetch_valid & decode_ready;
  assign resp_keep     = (state == WAIT) & imem_resp_valid & ~redirect_valid;
  assign out_free      = ~fetch_valid | decode_fire;

  // Older data in the skid always reaches decode before a fresh response.
  assign out_from_skid = decode_fire & skid_valid & ~redirect_valid;
  assign out_from_resp = resp_keep & out_free & ~out_from_skid;
  assign skid_load     = resp_keep & (~out_free | out_from_skid);

  // ------------------------------------------------------------------
  // Request-tracking FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // Responses seen here are strays (e.g. issued before a reset).
        if (req_fire) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // A response arriving with the redirect retires the request now;
          // otherwise its late response must still be swallowed.
          state_nxt = imem_resp_valid ? IDLE : DROP;
        end else if (imem_resp_valid) begin
          state_nxt = IDLE;
        end
      end
      DROP: begin
        // Leaving on the response even under a redirect avoids waiting
        // forever for a response that will never come.
        if (imem_resp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Program counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= BOOT_ADDRESS;
      req_pc <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_target & ALIGN_MASK;
    end else if (req_fire) begin
      req_pc <= pc;
      pc     <= pc + PC_STEP;  // wraps silently at the top of the address space
    end
  end

  // ------------------------------------------------------------------
  // Output pipeline register towards decode
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid       <= 1'b0;
      fetch_instruction <= '0;
      fetch_pc          <= '0;
    end else if (redirect_valid) begin
      fetch_valid <= 1'b0;
    end else if (out_from_skid) begin
      fetch_valid       <= 1'b1;
      fetch_instruction <= skid_instruction;
      fetch_pc          <= skid_pc;
    end else if (out_from_resp) begin
      fetch_valid       <= 1'b1;
      fetch_instruction <= imem_resp_data;
      fetch_pc          <= req_pc;
    end else if (decode_fire) begin
      fetch_valid <= 1'b0;
    end
  end

  fetch_skid_buffer #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .INSTR_SIZE   (INSTR_SIZE)
  ) u_skid (
    .clk              (clk),
    .reset            (reset),
    .load             (skid_load),
    .load_instruction (imem_resp_data),
    .load_pc          (req_pc),
    .drain            (out_from_skid),
    .clear            (redirect_valid),
    .valid            (skid_valid),
    .instruction      (skid_instruction),
    .pc               (skid_pc)
  );

endmodule
